// File: rtl/fp32_multiplier_if.sv
// Operand/result bundle for fp32_multiplier: decomposed operands in, packed product and flags out.
// With FPU_MUL_UNDERFLOW_FLAG_EN defined, the bundle also carries except_underflow_o.
interface fp32_multiplier_if;
  logic        data_ready_i;
  logic [6:0]  rounding_mode_i;
  logic        x_sign_i;
  logic [7:0]  x_exp_i;
  logic [22:0] x_frac_i;
  logic        y_sign_i;
  logic [7:0]  y_exp_i;
  logic [22:0] y_frac_i;
  logic        x_infinity_i;
  logic        y_infinity_i;
  logic        x_nan_i;
  logic        y_nan_i;
  logic        data_valid_o;
  logic [31:0] z_o;
  logic        except_invalid_operation_o;
  logic        except_overflow_o;
`ifdef FPU_MUL_UNDERFLOW_FLAG_EN
  logic        except_underflow_o;

  modport master (
    output data_ready_i, rounding_mode_i, x_sign_i, x_exp_i, x_frac_i, y_sign_i, y_exp_i,
           y_frac_i, x_infinity_i, y_infinity_i, x_nan_i, y_nan_i,
    input  data_valid_o, z_o, except_invalid_operation_o, except_overflow_o, except_underflow_o
  );
  modport slave (
    input  data_ready_i, rounding_mode_i, x_sign_i, x_exp_i, x_frac_i, y_sign_i, y_exp_i,
           y_frac_i, x_infinity_i, y_infinity_i, x_nan_i, y_nan_i,
    output data_valid_o, z_o, except_invalid_operation_o, except_overflow_o, except_underflow_o
  );
`else
  modport master (
    output data_ready_i, rounding_mode_i, x_sign_i, x_exp_i, x_frac_i, y_sign_i, y_exp_i,
           y_frac_i, x_infinity_i, y_infinity_i, x_nan_i, y_nan_i,
    input  data_valid_o, z_o, except_invalid_operation_o, except_overflow_o
  );
  modport slave (
    input  data_ready_i, rounding_mode_i, x_sign_i, x_exp_i, x_frac_i, y_sign_i, y_exp_i,
           y_frac_i, x_infinity_i, y_infinity_i, x_nan_i, y_nan_i,
    output data_valid_o, z_o, except_invalid_operation_o, except_overflow_o
  );
`endif
endinterface

// File: rtl/fp32_multiplier.sv
// Multicycle single-precision multiplier (MULT -> NORM -> ROUND -> DONE), denormals flushed.
// Optional FPU_MUL_UNDERFLOW_FLAG_EN adds an underflow flag for results flushed to zero.
module fp32_multiplier (
  input logic              clk_i,
  input logic              rst_i,
  fp32_multiplier_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StMult, StNorm, StRound, StDone} state_e;

  state_e state_q, state_d;

  logic        start;
  logic        rne_q, sign_q;
  logic [7:0]  xe_q, ye_q;
  logic [22:0] xf_q, yf_q;
  logic        xinf_q, yinf_q, xnan_q, ynan_q;

  logic        special_q, special_inv_q;
  logic [31:0] special_z_q;
  logic [47:0] prod_q;
  logic signed [9:0] exp_q;
  logic [22:0] frac_q;
  logic        guard_q, sticky_q;

  logic        valid_q, inv_q, ovf_q, unf_q;
  logic [31:0] z_q;

  assign start = ((state_q == StIdle) || (state_q == StDone)) && bus.data_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (bus.data_ready_i) state_d = StMult;
      StMult:         state_d = StNorm;
      StNorm:         state_d = StRound;
      StRound:        state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // MULT: special-case decode, mantissa product and unbiased exponent sum
  logic        x_zero, y_zero;
  logic        m_special, m_inv;
  logic [31:0] m_special_z;
  logic [47:0] m_prod;
  logic signed [9:0] m_exp;

  always_comb begin
    x_zero      = (xe_q == 8'd0);
    y_zero      = (ye_q == 8'd0);
    m_special   = 1'b1;
    m_inv       = 1'b0;
    m_special_z = 32'd0;
    if (xnan_q || ynan_q || (xinf_q && y_zero) || (yinf_q && x_zero)) begin
      m_special_z = 32'h7FFF_FFFF;
      m_inv       = 1'b1;
    end else if (xinf_q || yinf_q) begin
      m_special_z = {sign_q, 8'hFF, 23'd0};
    end else if (x_zero || y_zero) begin
      m_special_z = {sign_q, 31'd0};
    end else begin
      m_special   = 1'b0;
    end
    m_prod = {24'd0, 1'b1, xf_q} * {24'd0, 1'b1, yf_q};
    m_exp  = $signed({2'b00, xe_q}) + $signed({2'b00, ye_q}) - 10'sd127;
  end

  // ROUND: optional RNE increment; a mantissa carry-out leaves fraction zero and bumps exponent
  logic        r_inc;
  logic [23:0] r_mant;
  logic signed [9:0] r_exp;
  logic        r_ovf, r_unf;

  always_comb begin
    r_inc  = rne_q && guard_q && (sticky_q || frac_q[0]);
    r_mant = {1'b0, frac_q} + {23'd0, r_inc};
    r_exp  = exp_q + $signed({9'd0, r_mant[23]});
    r_ovf  = (r_exp >= 10'sd255);
    r_unf  = (r_exp <= 10'sd0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q       <= 1'b0;
      z_q           <= 32'd0;
      inv_q         <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      rne_q         <= 1'b0;
      sign_q        <= 1'b0;
      xe_q          <= 8'd0;
      ye_q          <= 8'd0;
      xf_q          <= 23'd0;
      yf_q          <= 23'd0;
      xinf_q        <= 1'b0;
      yinf_q        <= 1'b0;
      xnan_q        <= 1'b0;
      ynan_q        <= 1'b0;
      special_q     <= 1'b0;
      special_inv_q <= 1'b0;
      special_z_q   <= 32'd0;
      prod_q        <= 48'd0;
      exp_q         <= 10'sd0;
      frac_q        <= 23'd0;
      guard_q       <= 1'b0;
      sticky_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            rne_q   <= bus.rounding_mode_i[0];
            sign_q  <= bus.x_sign_i ^ bus.y_sign_i;
            xe_q    <= bus.x_exp_i;
            ye_q    <= bus.y_exp_i;
            xf_q    <= bus.x_frac_i;
            yf_q    <= bus.y_frac_i;
            xinf_q  <= bus.x_infinity_i;
            yinf_q  <= bus.y_infinity_i;
            xnan_q  <= bus.x_nan_i;
            ynan_q  <= bus.y_nan_i;
            valid_q <= 1'b0;
            inv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
          end else if (state_q == StDone) begin
            valid_q <= 1'b1;
          end
        end
        StMult: begin
          special_q     <= m_special;
          special_inv_q <= m_inv;
          special_z_q   <= m_special_z;
          prod_q        <= m_prod;
          exp_q         <= m_exp;
        end
        StNorm: begin
          if (prod_q[47]) begin
            frac_q   <= prod_q[46:24];
            guard_q  <= prod_q[23];
            sticky_q <= |prod_q[22:0];
            exp_q    <= exp_q + 10'sd1;
          end else begin
            frac_q   <= prod_q[45:23];
            guard_q  <= prod_q[22];
            sticky_q <= |prod_q[21:0];
          end
        end
        StRound: begin
          if (special_q) begin
            z_q   <= special_z_q;
            inv_q <= special_inv_q;
          end else if (r_ovf) begin
            z_q   <= {sign_q, 8'hFF, 23'd0};
            ovf_q <= 1'b1;
          end else if (r_unf) begin
            z_q   <= {sign_q, 31'd0};
            unf_q <= 1'b1;
          end else begin
            z_q   <= {sign_q, r_exp[7:0], r_mant[22:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_valid_o               = valid_q;
  assign bus.z_o                        = z_q;
  assign bus.except_invalid_operation_o = inv_q;
  assign bus.except_overflow_o          = ovf_q;
`ifdef FPU_MUL_UNDERFLOW_FLAG_EN
  assign bus.except_underflow_o         = unf_q;
`else
  logic unused_unf;
  assign unused_unf = unf_q;
`endif

endmodule

// File: tb/tb_fp32_multiplier.sv
// Randomised and directed bench for fp32_multiplier against an integer-arithmetic reference model.
module tb_fp32_multiplier;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  fp32_multiplier_if bus ();

  fp32_multiplier dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, rounded by comparing the discarded part against one half
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y, input bit rne,
                                  output logic [31:0] z, output bit inv, output bit ovf,
                                  output bit unf);
    bit s = x[31] ^ y[31];
    int ex = int'(x[30:23]);
    int ey = int'(y[30:23]);
    bit xnan = (ex == 255) && (x[22:0] != 0);
    bit ynan = (ey == 255) && (y[22:0] != 0);
    bit xinf = (ex == 255) && (x[22:0] == 0);
    bit yinf = (ey == 255) && (y[22:0] == 0);
    bit xz = (ex == 0);
    bit yz = (ey == 0);
    longint unsigned mx, my, p, kept, rem, half;
    int e, sh;
    inv = 0; ovf = 0; unf = 0;
    if (xnan || ynan || (xinf && yz) || (yinf && xz)) begin
      z = 32'h7FFF_FFFF; inv = 1; return;
    end
    if (xinf || yinf) begin
      z = {s, 8'hFF, 23'd0}; return;
    end
    if (xz || yz) begin
      z = {s, 31'd0}; return;
    end
    mx = 64'h80_0000 + 64'(x[22:0]);
    my = 64'h80_0000 + 64'(y[22:0]);
    p  = mx * my;
    e  = ex + ey - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin
      sh = 24; e++;
    end
    kept = p >> sh;
    rem  = p - (kept << sh);
    half = 64'd1 << (sh - 1);
    if (rne && ((rem > half) || ((rem == half) && kept[0]))) kept++;
    if (kept == (64'd1 << 24)) begin
      kept = 64'd1 << 23; e++;
    end
    if (e >= 255) begin
      z = {s, 8'hFF, 23'd0}; ovf = 1;
    end else if (e <= 0) begin
      z = {s, 31'd0}; unf = 1;
    end else begin
      z = {s, 8'(e), kept[22:0]};
    end
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [6:0] mode);
    bus.rounding_mode_i = mode;
    bus.x_sign_i        = x[31];
    bus.x_exp_i         = x[30:23];
    bus.x_frac_i        = x[22:0];
    bus.y_sign_i        = y[31];
    bus.y_exp_i         = y[30:23];
    bus.y_frac_i        = y[22:0];
    bus.x_infinity_i    = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    bus.y_infinity_i    = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    bus.x_nan_i         = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    bus.y_nan_i         = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
  endtask

  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [6:0] mode, input logic [31:0] exp_z, input bit exp_inv,
                       input bit exp_ovf, input bit exp_unf, input bit pulse_busy);
    int lat;
    @(negedge clk);
    drive(x, y, mode);
    bus.data_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.data_ready_i = 1'b0;
    check({tag, ".vclr"}, 32'(bus.data_valid_o), 32'd0);
    lat = 0;
    while (lat < 10) begin
      if (pulse_busy && lat == 1) begin
        drive(32'h4000_0000, 32'h4000_0000, 7'd1);
        bus.data_ready_i = 1'b1;
      end else begin
        bus.data_ready_i = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (bus.data_valid_o) break;
    end
    bus.data_ready_i = 1'b0;
    check({tag, ".lat"}, 32'(lat), 32'd4);
    check({tag, ".z"}, bus.z_o, exp_z);
    check({tag, ".inv"}, 32'(bus.except_invalid_operation_o), 32'(exp_inv));
    check({tag, ".ovf"}, 32'(bus.except_overflow_o), 32'(exp_ovf));
`ifdef FPU_MUL_UNDERFLOW_FLAG_EN
    check({tag, ".unf"}, 32'(bus.except_underflow_o), 32'(exp_unf));
`else
    if (exp_unf) n_tests += 0;
`endif
    @(posedge clk);
    #1;
    check({tag, ".hold_v"}, 32'(bus.data_valid_o), 32'd1);
    check({tag, ".hold_z"}, bus.z_o, exp_z);
  endtask

  task automatic dir(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [6:0] mode, input logic [31:0] z, input bit inv, input bit ovf);
    do_op(tag, x, y, mode, z, inv, ovf, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] x, y, rz, r;
    logic [6:0]  mode;
    bit          rinv, rovf, runf;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.data_ready_i = 1'b0;
    drive(32'd0, 32'd0, 7'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid", 32'(bus.data_valid_o), 32'd0);
    check("rst.z", bus.z_o, 32'd0);
    check("rst.inv", 32'(bus.except_invalid_operation_o), 32'd0);
    check("rst.ovf", 32'(bus.except_overflow_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    dir("t0", 32'h3FC00000, 32'h4500001A, 7'd0, 32'h45400027, 0, 0);
    dir("t1", 32'hC5FCE001, 32'h34D98E63, 7'd0, 32'hBB56E686, 0, 0);
    dir("t2", 32'h42C40666, 32'h41403333, 7'd0, 32'h44932C00, 0, 0);
    dir("t3", 32'h3F000000, 32'hBEE00000, 7'd0, 32'hBE600000, 0, 0);
    dir("z0", 32'h484C3381, 32'h00000000, 7'd0, 32'h00000000, 0, 0);
    dir("z1", 32'h4479FF5C, 32'h80000000, 7'd0, 32'h80000000, 0, 0);
    dir("i0", 32'hFF800000, 32'h4479FF5C, 7'd0, 32'hFF800000, 0, 0);
    dir("i1", 32'h7F800000, 32'hFF800000, 7'd0, 32'hFF800000, 0, 0);
    dir("n0", 32'h7F800000, 32'h00000000, 7'd0, 32'h7FFFFFFF, 1, 0);
    dir("n1", 32'h3DB8D4FE, 32'hFFFFFFFF, 7'd0, 32'h7FFFFFFF, 1, 0);
    dir("n2", 32'h7FFFFFFF, 32'h7F800000, 7'd0, 32'h7FFFFFFF, 1, 0);
    dir("o0", 32'h7F61B1E6, 32'h7E348E52, 7'd0, 32'h7F800000, 0, 1);
    dir("o1", 32'hFF6F4447, 32'hFE879AE3, 7'd0, 32'h7F800000, 0, 1);
    dir("o2", 32'h7F7FFFFF, 32'hFCF0BDC2, 7'd0, 32'hFF800000, 0, 1);
    dir("r0", 32'hC5FCE001, 32'h34D98E63, 7'd1, 32'hBB56E687, 0, 0);
    dir("r1", 32'h4238147B, 32'hC21F36AE, 7'd1, 32'hC4E4F814, 0, 0);
    dir("r2", 32'h42C40666, 32'h41403333, 7'd1, 32'h44932C01, 0, 0);
    dir("r3", 32'h4479FF5C, 32'h3C23D70A, 7'd1, 32'h411FFF97, 0, 0);
    // Underflow: tiny x tiny flushes to signed zero
    do_op("uf", 32'h00800001, 32'h80800000, 7'd0, 32'h80000000, 0, 0, 1, 0);

    // Start pulse during MULT/NORM must not disturb the running operation
    do_op("busy", 32'h3FC00000, 32'h4500001A, 7'd0, 32'h45400027, 0, 0, 0, 1);

    // Reset while the pipeline is in NORM
    @(negedge clk);
    drive(32'h40400000, 32'h40400000, 7'd0);
    bus.data_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.data_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rstmid.valid", 32'(bus.data_valid_o), 32'd0);
    check("rstmid.z", bus.z_o, 32'd0);
    check("rstmid.ovf", 32'(bus.except_overflow_o), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("rstmid.idle", 32'(bus.data_valid_o), 32'd0);
    dir("post", 32'h40400000, 32'h40400000, 7'd0, 32'h41100000, 0, 0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom();
      x = $urandom();
      y = $urandom();
      case (r[3:0])
        4'd0: x[30:23] = 8'd0;
        4'd1: y[30:23] = 8'hFF;
        4'd2: begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end
        4'd3: y[30:23] = 8'd0;
        default: begin
          x[30:23] = 8'(60 + (r[15:8] % 8'd136));
          y[30:23] = 8'(60 + (r[23:16] % 8'd136));
        end
      endcase
      mode = {r[30:25], r[24]};
      ref_mul(x, y, mode[0], rz, rinv, rovf, runf);
      do_op($sformatf("rnd%0d", i), x, y, mode, rz, rinv, rovf, runf, r[31]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation limit reached, expected completion");
    $fatal(1);
  end

endmodule
